alu_issue_queue: RTL and testbench

ALU_ISSUE_QUEUE -- requirements
Module: alu_issue_queue

---
 rtl/alu_issue_queue_pkg.sv | 34 +++
 rtl/alu_issue_queue_if.sv | 47 ++++
 rtl/alu_issue_queue_picker.sv | 24 ++
 rtl/alu_issue_queue.sv | 124 ++++++++++++
 tb/tb_alu_issue_queue.sv | 277 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_issue_queue_pkg.sv
// Shared types for the ALU issue queue: opcode constants, tag width and the queue entry layout.
package alu_pkg;

    localparam int PREG_W = 6;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;

    typedef struct packed {
        logic              valid;
        logic [6:0]        opcode;
        logic [2:0]        func3;
        logic [6:0]        func7;
        logic [PREG_W-1:0] ps1;
        logic [PREG_W-1:0] ps2;
        logic [PREG_W-1:0] pd;
        logic              rdy1;
        logic              rdy2;
        logic [31:0]       imm;
    } iq_entry_t;

    // Tag 0 is the hardwired zero register, so a broadcast of 0 never wakes anything.
    function automatic logic tag_hit(input logic wb_valid, input logic [PREG_W-1:0] wb_pd,
                                     input logic [PREG_W-1:0] tag);
        return wb_valid && (wb_pd != '0) && (wb_pd == tag);
    endfunction

    function automatic logic uses_imm(input logic [6:0] opcode);
        return (opcode == OP_I) || (opcode == OP_LW);
    endfunction

endpackage

// File: rtl/alu_issue_queue_if.sv
// Dispatch, wakeup, flush and issue signals of the ALU issue queue.
interface alu_issue_queue_if #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = alu_pkg::PREG_W
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              disp_valid;
    logic              disp_ready;
    logic [6:0]        disp_opcode;
    logic [2:0]        disp_func3;
    logic [6:0]        disp_func7;
    logic [PREG_W-1:0] disp_ps1;
    logic [PREG_W-1:0] disp_ps2;
    logic [PREG_W-1:0] disp_pd;
    logic              disp_rdy1;
    logic              disp_rdy2;
    logic [31:0]       disp_imm;

    logic              wb_valid;
    logic [PREG_W-1:0] wb_pd;
    logic              flush;

    logic              iss_valid;
    logic [6:0]        iss_opcode;
    logic [2:0]        iss_func3;
    logic [6:0]        iss_func7;
    logic [PREG_W-1:0] iss_ps1;
    logic [PREG_W-1:0] iss_ps2;
    logic [PREG_W-1:0] iss_pd;
    logic [31:0]       iss_imm;
    logic [CNT_W-1:0]  count;

    modport master (
        output disp_valid, disp_opcode, disp_func3, disp_func7, disp_ps1, disp_ps2, disp_pd,
               disp_rdy1, disp_rdy2, disp_imm, wb_valid, wb_pd, flush,
        input  disp_ready, iss_valid, iss_opcode, iss_func3, iss_func7, iss_ps1, iss_ps2,
               iss_pd, iss_imm, count
    );

    modport slave (
        input  disp_valid, disp_opcode, disp_func3, disp_func7, disp_ps1, disp_ps2, disp_pd,
               disp_rdy1, disp_rdy2, disp_imm, wb_valid, wb_pd, flush,
        output disp_ready, iss_valid, iss_opcode, iss_func3, iss_func7, iss_ps1, iss_ps2,
               iss_pd, iss_imm, count
    );
endinterface

// File: rtl/alu_issue_queue_picker.sv
// Combinational lowest-index-first picker; index 0 is the oldest entry.
module oldest_ready_picker #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]         req,
    output logic [DEPTH-1:0]         grant,
    output logic [$clog2(DEPTH)-1:0] idx,
    output logic                     any_valid
);
    always_comb begin
        grant     = '0;
        idx       = '0;
        any_valid = 1'b0;
        // Scan downward so the lowest set bit is the final winner.
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (req[i]) begin
                grant     = '0;
                grant[i]  = 1'b1;
                idx       = ($clog2(DEPTH))'(i);
                any_valid = 1'b1;
            end
        end
    end
endmodule

// File: rtl/alu_issue_queue.sv
// Age-ordered, compacting ALU issue queue: wakeup by tag broadcast, oldest-ready single issue.
module alu_issue_queue #(
    parameter int DEPTH  = 8,
    parameter int PREG_W = alu_pkg::PREG_W
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_issue_queue_if.slave iq
);
    import alu_pkg::*;

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    iq_entry_t [DEPTH-1:0] q;
    iq_entry_t [DEPTH-1:0] q_n;
    iq_entry_t [DEPTH:0]   cand;
    iq_entry_t             new_e;
    iq_entry_t             iss_sel;

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_n;
    logic [DEPTH-1:0] req;
    logic [DEPTH-1:0] grant;
    logic [IDX_W-1:0] pick_idx;
    logic             issue;
    logic             do_disp;

    assign iq.disp_ready = (count_r < CNT_W'(DEPTH));
    assign iq.count      = count_r;
    assign do_disp       = iq.disp_valid && iq.disp_ready;

    always_comb begin
        new_e        = '0;
        new_e.valid  = 1'b1;
        new_e.opcode = iq.disp_opcode;
        new_e.func3  = iq.disp_func3;
        new_e.func7  = iq.disp_func7;
        new_e.ps1    = iq.disp_ps1;
        new_e.ps2    = iq.disp_ps2;
        new_e.pd     = iq.disp_pd;
        new_e.imm    = iq.disp_imm;
        new_e.rdy1   = iq.disp_rdy1 || (iq.disp_ps1 == '0) ||
                       tag_hit(iq.wb_valid, iq.wb_pd, iq.disp_ps1);
        new_e.rdy2   = iq.disp_rdy2 || (iq.disp_ps2 == '0) || uses_imm(iq.disp_opcode) ||
                       tag_hit(iq.wb_valid, iq.wb_pd, iq.disp_ps2);
    end

    // The incoming instruction occupies the first free slot as a candidate, so an
    // already-ready dispatch into an idle queue can be picked in its own cycle.
    // Queued entries are picked on registered readiness; wakeups land next cycle.
    always_comb begin
        cand = '0;
        req  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q[i].valid) begin
                cand[i]      = q[i];
                cand[i].rdy1 = q[i].rdy1 | tag_hit(iq.wb_valid, iq.wb_pd, q[i].ps1);
                cand[i].rdy2 = q[i].rdy2 | tag_hit(iq.wb_valid, iq.wb_pd, q[i].ps2);
                req[i]       = q[i].rdy1 & q[i].rdy2;
            end else if (do_disp && (i == int'(count_r))) begin
                cand[i] = new_e;
                req[i]  = new_e.rdy1 & new_e.rdy2;
            end
        end
    end

    oldest_ready_picker #(.DEPTH(DEPTH)) u_picker (
        .req       (req),
        .grant     (grant),
        .idx       (pick_idx),
        .any_valid (issue)
    );

    always_comb begin
        iss_sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i]) iss_sel = iss_sel | cand[i];
        end
    end

    // Close the gap left by the issued entry; cand[DEPTH] is always empty.
    always_comb begin
        q_n = cand[DEPTH-1:0];
        for (int i = 0; i < DEPTH; i++) begin
            if (issue && (i >= int'(pick_idx))) q_n[i] = cand[i+1];
        end
    end

    assign count_n = count_r + CNT_W'(do_disp) - CNT_W'(issue);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q             <= '0;
            count_r       <= '0;
            iq.iss_valid  <= 1'b0;
            iq.iss_opcode <= '0;
            iq.iss_func3  <= '0;
            iq.iss_func7  <= '0;
            iq.iss_ps1    <= '0;
            iq.iss_ps2    <= '0;
            iq.iss_pd     <= '0;
            iq.iss_imm    <= '0;
        end else if (iq.flush) begin
            q            <= '0;
            count_r      <= '0;
            iq.iss_valid <= 1'b0;
        end else begin
            q            <= q_n;
            count_r      <= count_n;
            iq.iss_valid <= issue;
            if (issue) begin
                iq.iss_opcode <= iss_sel.opcode;
                iq.iss_func3  <= iss_sel.func3;
                iq.iss_func7  <= iss_sel.func7;
                iq.iss_ps1    <= iss_sel.ps1;
                iq.iss_ps2    <= iss_sel.ps2;
                iq.iss_pd     <= iss_sel.pd;
                iq.iss_imm    <= iss_sel.imm;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized and directed bench for alu_issue_queue against a queue-based reference model.
module tb_alu_issue_queue;

    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_issue_queue_if #(.DEPTH(DEPTH), .PREG_W(6)) iq ();

    alu_issue_queue #(.DEPTH(DEPTH), .PREG_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .iq    (iq)
    );

    typedef struct {
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [5:0]  ps1;
        logic [5:0]  ps2;
        logic [5:0]  pd;
        logic [31:0] imm;
        bit          r1;
        bit          r2;
    } m_ent_t;

    m_ent_t mq[$];
    m_ent_t m_iss;
    bit     m_iv;
    bit     m_live = 0;
    int     n_vec = 0;
    int     n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit hit(input logic [5:0] t);
        return iq.wb_valid && (iq.wb_pd != 0) && (iq.wb_pd == t);
    endfunction

    // Reference: list of waiting instructions, oldest first; new arrival appended.
    always @(posedge clk) begin
        if (!rst_n) begin
            mq.delete();
            m_iv   = 0;
            m_iss  = '{default: '0};
            m_live = 1;
        end else if (iq.flush) begin
            mq.delete();
            m_iv = 0;
        end else begin
            int     k;
            bit     acc;
            m_ent_t ne;
            k   = -1;
            acc = iq.disp_valid && (mq.size() < DEPTH);
            for (int i = 0; i < mq.size(); i++)
                if (mq[i].r1 && mq[i].r2) begin k = i; break; end
            for (int i = 0; i < mq.size(); i++) begin
                if (hit(mq[i].ps1)) mq[i].r1 = 1;
                if (hit(mq[i].ps2)) mq[i].r2 = 1;
            end
            if (acc) begin
                ne.op  = iq.disp_opcode; ne.f3 = iq.disp_func3; ne.f7 = iq.disp_func7;
                ne.ps1 = iq.disp_ps1; ne.ps2 = iq.disp_ps2; ne.pd = iq.disp_pd;
                ne.imm = iq.disp_imm;
                ne.r1  = iq.disp_rdy1 || iq.disp_ps1 == 0 || hit(iq.disp_ps1);
                ne.r2  = iq.disp_rdy2 || iq.disp_ps2 == 0 || hit(iq.disp_ps2) ||
                         iq.disp_opcode == 7'b0010011 || iq.disp_opcode == 7'b0000011;
                mq.push_back(ne);
                if (k < 0 && ne.r1 && ne.r2) k = mq.size() - 1;
            end
            if (k >= 0) begin
                m_iss = mq[k];
                mq.delete(k);
                m_iv = 1;
            end else begin
                m_iv = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("iss_valid", {31'b0, iq.iss_valid}, {31'b0, m_iv});
            chk("count", {28'b0, iq.count}, mq.size());
            chk("disp_ready", {31'b0, iq.disp_ready}, {31'b0, mq.size() < DEPTH});
            chk("iss_opcode", {25'b0, iq.iss_opcode}, {25'b0, m_iss.op});
            chk("iss_func", {22'b0, iq.iss_func3, iq.iss_func7}, {22'b0, m_iss.f3, m_iss.f7});
            chk("iss_tags", {14'b0, iq.iss_ps1, iq.iss_ps2, iq.iss_pd},
                {14'b0, m_iss.ps1, m_iss.ps2, m_iss.pd});
            chk("iss_imm", iq.iss_imm, m_iss.imm);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        iq.disp_valid = 0;
        iq.wb_valid   = 0;
        iq.wb_pd      = 0;
        iq.flush      = 0;
    endtask

    task automatic disp(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [5:0] ps1, input logic [5:0] ps2, input logic [5:0] pd,
                        input logic r1, input logic r2, input logic [31:0] imm);
        iq.disp_valid = 1; iq.disp_opcode = op; iq.disp_func3 = f3; iq.disp_func7 = f7;
        iq.disp_ps1 = ps1; iq.disp_ps2 = ps2; iq.disp_pd = pd;
        iq.disp_rdy1 = r1; iq.disp_rdy2 = r2; iq.disp_imm = imm;
    endtask

    task automatic wake(input logic [5:0] t);
        iq.wb_valid = 1;
        iq.wb_pd    = t;
    endtask

    task automatic do_flush();
        idle();
        iq.flush = 1;
        step();
        iq.flush = 0;
    endtask

    initial begin
        idle();
        disp(7'b0110011, 0, 0, 0, 0, 0, 0, 0, 0);
        iq.disp_valid = 0;
        rst_n = 0;
        step(); step();
        rst_n = 1;
        chk("rst iss_valid", {31'b0, iq.iss_valid}, 0);
        chk("rst count", {28'b0, iq.count}, 0);
        chk("rst disp_ready", {31'b0, iq.disp_ready}, 1);
        chk("rst iss_pd", {26'b0, iq.iss_pd}, 0);

        // ADD p5 = p1 + p2, both ready
        disp(7'b0110011, 3'd0, 7'd0, 6'd1, 6'd2, 6'd5, 1, 1, 0);
        step(); idle();
        chk("add iss_valid", {31'b0, iq.iss_valid}, 1);
        chk("add iss_pd", {26'b0, iq.iss_pd}, 5);
        chk("add count", {28'b0, iq.count}, 0);
        step();

        // SUB waits on p7, ADDI bypasses it
        disp(7'b0110011, 3'd0, 7'b0100000, 6'd7, 6'd1, 6'd10, 0, 1, 0);
        step();
        disp(7'b0010011, 3'd0, 7'd0, 6'd3, 6'd4, 6'd11, 1, 0, 32'hFFFF_FFF0);
        step(); idle();
        chk("addi first", {31'b0, iq.iss_valid}, 1);
        chk("addi pd", {26'b0, iq.iss_pd}, 11);
        chk("addi imm", iq.iss_imm, 32'hFFFF_FFF0);
        step(); step();
        wake(6'd7);
        step(); idle();
        chk("sub not yet", {31'b0, iq.iss_valid}, 0);
        step();
        chk("sub issues c6", {31'b0, iq.iss_valid}, 1);
        chk("sub pd", {26'b0, iq.iss_pd}, 10);
        chk("sub func7", {25'b0, iq.iss_func7}, 7'b0100000);
        do_flush();

        // Fill with eight waiting entries
        for (int i = 0; i < DEPTH; i++) begin
            disp(7'b0110011, 3'd0, 7'd0, 6'(20 + i), 6'd1, 6'(40 + i), 0, 1, 0);
            step();
        end
        idle();
        chk("full count", {28'b0, iq.count}, 8);
        chk("full disp_ready", {31'b0, iq.disp_ready}, 0);
        disp(7'b0110011, 3'd0, 7'd0, 6'd1, 6'd2, 6'd60, 1, 1, 0);
        step(); idle();
        chk("full refuses", {28'b0, iq.count}, 8);
        chk("full no issue", {31'b0, iq.iss_valid}, 0);
        wake(6'd22);
        step(); idle();
        step();
        chk("wake2 issue", {31'b0, iq.iss_valid}, 1);
        chk("wake2 pd", {26'b0, iq.iss_pd}, 42);
        chk("wake2 count", {28'b0, iq.count}, 7);
        chk("wake2 ready", {31'b0, iq.disp_ready}, 1);
        step();
        chk("wake2 single", {31'b0, iq.iss_valid}, 0);
        do_flush();

        // Same-cycle wakeup capture, then a zero broadcast that must not wake
        disp(7'b0110011, 3'b100, 7'd0, 6'd1, 6'd9, 6'd14, 1, 0, 0);
        wake(6'd9);
        step(); idle();
        chk("xor issues", {31'b0, iq.iss_valid}, 1);
        chk("xor pd", {26'b0, iq.iss_pd}, 14);
        disp(7'b0110011, 3'd0, 7'd0, 6'd0, 6'd13, 6'd15, 0, 0, 0);
        wake(6'd0);
        step(); iq.disp_valid = 0;
        step(); step();
        chk("wb0 no wake", {31'b0, iq.iss_valid}, 0);
        chk("wb0 count", {28'b0, iq.count}, 1);
        wake(6'd13);
        step(); idle();
        step();
        chk("p13 wake", {31'b0, iq.iss_valid}, 1);
        chk("p13 pd", {26'b0, iq.iss_pd}, 15);
        step();

        // Flush with a same-cycle ready dispatch and wakeup
        for (int i = 0; i < 4; i++) begin
            disp(7'b0110011, 3'd0, 7'd0, 6'(30 + i), 6'd1, 6'(50 + i), 0, 1, 0);
            step();
        end
        disp(7'b0110011, 3'd0, 7'd0, 6'd1, 6'd2, 6'd55, 1, 1, 0);
        wake(6'd30);
        iq.flush = 1;
        step(); idle();
        chk("flush count", {28'b0, iq.count}, 0);
        for (int i = 0; i < 3; i++) begin
            chk("flush no issue", {31'b0, iq.iss_valid}, 0);
            step();
        end

        // Reset while three woken entries wait
        for (int i = 0; i < 3; i++) begin
            disp(7'b0110011, 3'd0, 7'd0, 6'd37, 6'd1, 6'(20 + i), 0, 1, 0);
            step();
        end
        idle();
        wake(6'd37);
        step(); idle();
        rst_n = 0;
        step();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            chk("rst mid iss_valid", {31'b0, iq.iss_valid}, 0);
            chk("rst mid count", {28'b0, iq.count}, 0);
            step();
        end
        chk("rst mid pd", {26'b0, iq.iss_pd}, 0);

        // Random traffic, small tag space so wakeups collide often
        for (int c = 0; c < 800; c++) begin
            logic [6:0] op;
            case ($urandom_range(0, 4))
                0: op = 7'b0110011;
                1: op = 7'b0010011;
                2: op = 7'b0000011;
                3: op = 7'b0100011;
                default: op = 7'($urandom);
            endcase
            disp(op, 3'($urandom), 7'($urandom), 6'($urandom_range(0, 15)),
                 6'($urandom_range(0, 15)), 6'($urandom_range(0, 63)),
                 $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom);
            iq.disp_valid = $urandom_range(0, 3) != 0;
            iq.wb_valid   = $urandom_range(0, 1) == 1;
            iq.wb_pd      = 6'($urandom_range(0, 15));
            iq.flush      = $urandom_range(0, 80) == 0;
            rst_n         = $urandom_range(0, 300) != 0;
            step();
        end
        idle();
        rst_n = 1;
        step(); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
